decode_cycle: RTL and testbench

- Second stage of the 5-stage RV32I pipeline. Sits directly downstream of fetch_cycle and consumes its IF/ID outputs (InstrD, PCD, PCPlus4D).
- Decodes the instruction, reads the 32x32 register file, which is written by the writeback stage, and sign-extends the immediate.
- Registers all control and data into the ID/EX pipeline register that feeds execute_cycle.
- Exposes Rs1D/Rs2D to the hazard unit and accepts FlushE, which inserts a bubble into ID/EX.

---
 rtl/decode_cycle.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, 32x32 register file with write-through
// bypass, immediate extension and the ID/EX pipeline register with bubble insert.
module decode_cycle #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic [2:0]      ALUControlE,
   output logic            ALUSrcE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      RdE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7_5;
   logic [4:0]      rd;

   logic            reg_write;
   logic [1:0]      imm_src;
   logic            imm_en;
   logic            alu_src;
   logic            mem_write;
   logic [1:0]      result_src;
   logic            branch;
   logic [1:0]      alu_op;
   logic            jump;
   logic [2:0]      alu_control;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            wb_active;

   logic [XLEN-1:0] regs [NREGS];

   assign opcode   = InstrD[6:0];
   assign funct3   = InstrD[14:12];
   assign funct7_5 = InstrD[30];
   assign rd       = InstrD[11:7];
   assign Rs1D     = InstrD[19:15];
   assign Rs2D     = InstrD[24:20];

   // Main decoder: unknown opcodes decode to an all-zero bubble.
   always_comb begin
      reg_write  = 1'b0;
      imm_src    = 2'b00;
      imm_en     = 1'b0;
      alu_src    = 1'b0;
      mem_write  = 1'b0;
      result_src = 2'b00;
      branch     = 1'b0;
      alu_op     = 2'b00;
      jump       = 1'b0;
      case (opcode)
         7'b0000011: begin
            reg_write  = 1'b1;
            imm_en     = 1'b1;
            alu_src    = 1'b1;
            result_src = 2'b01;
         end
         7'b0100011: begin
            imm_src   = 2'b01;
            imm_en    = 1'b1;
            alu_src   = 1'b1;
            mem_write = 1'b1;
         end
         7'b0110011: begin
            reg_write = 1'b1;
            alu_op    = 2'b10;
         end
         7'b0010011: begin
            reg_write = 1'b1;
            imm_en    = 1'b1;
            alu_src   = 1'b1;
            alu_op    = 2'b10;
         end
         7'b1100011: begin
            imm_src = 2'b10;
            imm_en  = 1'b1;
            branch  = 1'b1;
            alu_op  = 2'b01;
         end
         7'b1101111: begin
            reg_write  = 1'b1;
            imm_src    = 2'b11;
            imm_en     = 1'b1;
            result_src = 2'b10;
            jump       = 1'b1;
         end
         default: begin
            reg_write = 1'b0;
         end
      endcase
   end

   // ALU decoder; only register-register ops use funct7 to select sub.
   always_comb begin
      alu_control = 3'b000;
      case (alu_op)
         2'b01: alu_control = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  alu_control = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
               3'b010:  alu_control = 3'b101;
               3'b110:  alu_control = 3'b011;
               3'b111:  alu_control = 3'b010;
               default: alu_control = 3'b000;
            endcase
         end
         default: alu_control = 3'b000;
      endcase
   end

   // Immediate extension, sign taken from InstrD[31].
   always_comb begin
      imm_ext = '0;
      if (imm_en) begin
         case (imm_src)
            2'b00:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            2'b01:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                                InstrD[11:8], 1'b0};
            2'b11:   imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                                InstrD[30:21], 1'b0};
            default: imm_ext = '0;
         endcase
      end else begin
         imm_ext = '0;
      end
   end

   assign wb_active = RegWriteW && (RDW != 5'd0);

   // Register read with write-through so ID/EX captures same-cycle writebacks.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (Rs1D == 5'd0) begin
         rd1 = '0;
      end else if (wb_active && (RDW == Rs1D)) begin
         rd1 = ResultW;
      end else begin
         rd1 = regs[Rs1D];
      end
      if (Rs2D == 5'd0) begin
         rd2 = '0;
      end else if (wb_active && (RDW == Rs2D)) begin
         rd2 = ResultW;
      end else begin
         rd2 = regs[Rs2D];
      end
   end

   // Register file storage; a writeback on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_active) begin
         regs[RDW] <= ResultW;
      end
   end

   // ID/EX pipeline register: flush zeroes control and register indices only.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= 2'b00;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUControlE <= 3'b000;
         ALUSrcE     <= 1'b0;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         RdE         <= 5'd0;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RD1E     <= rd1;
         RD2E     <= rd2;
         ImmExtE  <= imm_ext;
         PCE      <= PCD;
         PCPlus4E <= PCPlus4D;
         if (FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ALUSrcE     <= 1'b0;
            RdE         <= 5'd0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
         end else begin
            RegWriteE   <= reg_write;
            ResultSrcE  <= result_src;
            MemWriteE   <= mem_write;
            JumpE       <= jump;
            BranchE     <= branch;
            ALUControlE <= alu_control;
            ALUSrcE     <= alu_src;
            RdE         <= rd;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
         end
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed-vector bench for decode_cycle; each task checks its own scenario inline.
module tb_decode_cycle;

   logic        clk;
   logic        rst;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RDW;
   logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

   int total = 0;
   int bad   = 0;

   decode_cycle dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E),
      .ImmExtE(ImmExtE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE),
      .PCPlus4E(PCPlus4E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] instr, input logic [31:0] pc);
      InstrD   = instr;
      PCD      = pc;
      PCPlus4D = pc + 32'd4;
   endtask

   task automatic test_reset();
      rst = 1'b1; FlushE = 1'b0;
      RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h0000_1234;
      set_instr(32'h0050_0093, 32'h0000_0040);
      tick(); tick();
      total++;
      if ({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
           RdE, Rs1E, Rs2E} !== 25'd0) begin
         bad++;
         $display("FAIL reset_ctrl got=%0h want=0",
                  {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                   ALUSrcE, RdE, Rs1E, Rs2E});
      end
      total++;
      if ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E} !== 160'd0) begin
         bad++;
         $display("FAIL reset_data got=%0h want=0", {RD1E, RD2E, ImmExtE, PCE, PCPlus4E});
      end
      rst = 1'b0; RegWriteW = 1'b0;
      set_instr(32'h0000_8013, 32'h0000_0000);   // addi x0,x1,0 reads x1
      tick();
      total++;
      if (RD1E !== 32'd0) begin
         bad++;
         $display("FAIL reset_x1 got=%0h want=0", RD1E);
      end
   endtask

   task automatic test_addi();
      set_instr(32'h0050_0093, 32'h0000_0010);
      #1;
      total++;
      if ({Rs1D, Rs2D} !== {5'd0, 5'd5}) begin
         bad++;
         $display("FAIL addi_rsd got=%0h/%0h want=0/5", Rs1D, Rs2D);
      end
      tick();
      total++;
      if ({RegWriteE, ALUSrcE, ALUControlE, ResultSrcE, MemWriteE, BranchE, JumpE, RdE}
          !== {1'b1, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1}) begin
         bad++;
         $display("FAIL addi_ctrl rw=%0b as=%0b alu=%0b rs=%0b rd=%0d", RegWriteE,
                  ALUSrcE, ALUControlE, ResultSrcE, RdE);
      end
      total++;
      if ({ImmExtE, RD1E, PCE, PCPlus4E} !== {32'd5, 32'd0, 32'h10, 32'h14}) begin
         bad++;
         $display("FAIL addi_data imm=%0h rd1=%0h pc=%0h pc4=%0h want=5/0/10/14",
                  ImmExtE, RD1E, PCE, PCPlus4E);
      end
   endtask

   task automatic test_bypass();
      RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h1111_1111;
      set_instr(32'h0000_0000, 32'h0000_0014);
      tick();
      RDW = 5'd2; ResultW = 32'hDEAD_BEEF;
      set_instr(32'h4020_8233, 32'h0000_0018);
      tick();
      total++;
      if ({RD1E, RD2E} !== {32'h1111_1111, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL bypass_data rd1=%0h rd2=%0h want=11111111/deadbeef", RD1E, RD2E);
      end
      total++;
      if ({ALUControlE, ALUSrcE, RegWriteE, RdE, Rs1E, Rs2E}
          !== {3'b001, 1'b0, 1'b1, 5'd4, 5'd1, 5'd2}) begin
         bad++;
         $display("FAIL bypass_ctrl alu=%0b as=%0b rw=%0b rd=%0d rs1=%0d rs2=%0d",
                  ALUControlE, ALUSrcE, RegWriteE, RdE, Rs1E, Rs2E);
      end
      RegWriteW = 1'b0; ResultW = 32'h0;
      tick();
      total++;
      if (RD2E !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL stored_x2 got=%0h want=deadbeef", RD2E);
      end
   endtask

   task automatic test_x0();
      RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hFFFF_FFFF;
      set_instr(32'h0050_0093, 32'h0000_0020);
      tick();
      total++;
      if (RD1E !== 32'd0) begin
         bad++;
         $display("FAIL x0_bypass got=%0h want=0", RD1E);
      end
      RegWriteW = 1'b0;
      tick();
      total++;
      if (RD1E !== 32'd0) begin
         bad++;
         $display("FAIL x0_stored got=%0h want=0", RD1E);
      end
   endtask

   task automatic test_immediates();
      set_instr(32'hFE00_0EE3, 32'h0000_0030);   // beq x0,x0,-4
      tick();
      total++;
      if ({BranchE, RegWriteE, ALUSrcE, ALUControlE, ImmExtE}
          !== {1'b1, 1'b0, 1'b0, 3'b001, 32'hFFFF_FFFC}) begin
         bad++;
         $display("FAIL beq br=%0b rw=%0b as=%0b alu=%0b imm=%0h want 1/0/0/001/fffffffc",
                  BranchE, RegWriteE, ALUSrcE, ALUControlE, ImmExtE);
      end
      set_instr(32'h0080_006F, 32'h0000_0034);   // jal x0,8
      tick();
      total++;
      if ({JumpE, ResultSrcE, RegWriteE, BranchE, ImmExtE}
          !== {1'b1, 2'b10, 1'b1, 1'b0, 32'd8}) begin
         bad++;
         $display("FAIL jal j=%0b rs=%0b rw=%0b br=%0b imm=%0h want 1/10/1/0/8",
                  JumpE, ResultSrcE, RegWriteE, BranchE, ImmExtE);
      end
      set_instr(32'h0020_A423, 32'h0000_0038);   // sw x2,8(x1)
      tick();
      total++;
      if ({MemWriteE, RegWriteE, ALUSrcE, ALUControlE, ImmExtE, RD1E, RD2E}
          !== {1'b1, 1'b0, 1'b1, 3'b000, 32'd8, 32'h1111_1111, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL sw mw=%0b rw=%0b as=%0b alu=%0b imm=%0h rd1=%0h rd2=%0h",
                  MemWriteE, RegWriteE, ALUSrcE, ALUControlE, ImmExtE, RD1E, RD2E);
      end
      set_instr(32'hFFF0_A413, 32'h0000_003C);   // slti x8,x1,-1
      tick();
      total++;
      if ({ALUControlE, ImmExtE, RdE} !== {3'b101, 32'hFFFF_FFFF, 5'd8}) begin
         bad++;
         $display("FAIL slti alu=%0b imm=%0h rd=%0d want 101/ffffffff/8",
                  ALUControlE, ImmExtE, RdE);
      end
      set_instr(32'hFFFF_FFFF, 32'h0000_0040);   // unknown opcode
      tick();
      total++;
      if ({RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE, ImmExtE}
          !== {5'b00000, 2'b00, 3'b000, 32'd0}) begin
         bad++;
         $display("FAIL illegal rw=%0b mw=%0b as=%0b alu=%0b imm=%0h want all 0",
                  RegWriteE, MemWriteE, ALUSrcE, ALUControlE, ImmExtE);
      end
   endtask

   task automatic test_flush();
      FlushE = 1'b1;
      RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hCAFE_F00D;
      set_instr(32'h0000_A183, 32'h0000_0050);   // lw x3,0(x1)
      tick();
      total++;
      if ({RegWriteE, MemWriteE, ResultSrcE, ALUControlE, ALUSrcE, RdE, Rs1E, Rs2E}
          !== {1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0}) begin
         bad++;
         $display("FAIL flush rw=%0b mw=%0b rs=%0b as=%0b rd=%0d rs1=%0d want all 0",
                  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, RdE, Rs1E);
      end
      FlushE = 1'b0; RegWriteW = 1'b0;
      tick();
      total++;
      if ({ResultSrcE, RegWriteE, ALUSrcE, RdE, Rs1E, ImmExtE}
          !== {2'b01, 1'b1, 1'b1, 5'd3, 5'd1, 32'd0}) begin
         bad++;
         $display("FAIL lw rs=%0b rw=%0b as=%0b rd=%0d rs1=%0d imm=%0h want 01/1/1/3/1/0",
                  ResultSrcE, RegWriteE, ALUSrcE, RdE, Rs1E, ImmExtE);
      end
      set_instr(32'h0012_E3B3, 32'h0000_0054);   // or x7,x5,x1
      tick();
      total++;
      if ({ALUControlE, RD1E, RD2E, RdE} !== {3'b011, 32'hCAFE_F00D, 32'h1111_1111, 5'd7}) begin
         bad++;
         $display("FAIL flush_write alu=%0b rd1=%0h rd2=%0h rd=%0d want 011/cafef00d/11111111/7",
                  ALUControlE, RD1E, RD2E, RdE);
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; FlushE = 1'b1;
      RegWriteW = 1'b1; RDW = 5'd6; ResultW = 32'h0BAD_0BAD;
      set_instr(32'h0012_E3B3, 32'h0000_0058);
      tick();
      total++;
      if ({RegWriteE, ALUControlE, RdE, RD1E, RD2E, PCE}
          !== {1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0}) begin
         bad++;
         $display("FAIL reset_mid rw=%0b alu=%0b rd=%0d rd1=%0h rd2=%0h pc=%0h want all 0",
                  RegWriteE, ALUControlE, RdE, RD1E, RD2E, PCE);
      end
      rst = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0;
      set_instr(32'h0062_8233, 32'h0000_005C);   // add x4,x5,x6
      tick();
      total++;
      if ({RD1E, RD2E} !== {32'd0, 32'd0}) begin
         bad++;
         $display("FAIL reset_mid_regs rd1=%0h rd2=%0h want 0/0", RD1E, RD2E);
      end
   endtask

   initial begin
      rst = 1'b1; FlushE = 1'b0; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
      set_instr(32'd0, 32'd0);
      test_reset();
      test_addi();
      test_bypass();
      test_x0();
      test_immediates();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
